// File: rtl/fifo_fill_pkg.sv
// Shared types for the audio FIFO fill controller: FSM encoding, stat width,
// and the burst sizing helper.
package fifo_fill_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    WAIT_SPACE = 3'd2,
    REQ        = 3'd3,
    XFER       = 3'd4,
    DONE       = 3'd5
  } fill_state_e;

  localparam int STAT_W = 16;

  // Words for the next burst: the programmed maximum, or the tail if shorter.
  function automatic logic [7:0] clip_burst(input logic [63:0] remaining,
                                            input logic [7:0]  burst_max);
    if (remaining < {56'd0, burst_max}) return remaining[7:0];
    return burst_max;
  endfunction

endpackage

// File: rtl/fifo_fill_ctrl_if.sv
// Bundle of control, source handshake and FIFO write signals for fifo_fill_ctrl.
// Stat outputs exist only when FIFO_FILL_STAT_EN is defined.
interface fifo_fill_ctrl_if #(
  parameter int W     = 16,
  parameter int LEN_W = 32
);
  import fifo_fill_pkg::*;

  // Handshakes: req/ack is a level request held until ack is seen with req high;
  // a source beat transfers on any cycle where src_valid && src_ready.
  logic             start;
  logic [LEN_W-1:0] data_len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             req;
  logic [7:0]       burst_len;
  logic             ack;
  logic             src_valid;
  logic [W-1:0]     src_data;
  logic             src_ready;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_wr_data;
  logic             fifo_full;
  logic             fifo_afull;
  fill_state_e      dbg_state;
`ifdef FIFO_FILL_STAT_EN
  logic [STAT_W-1:0] burst_cnt;
  logic [STAT_W-1:0] stall_cnt;
`endif

  modport master (
    input  start, data_len, abort, ack, src_valid, src_data, fifo_full, fifo_afull,
    output busy, done, req, burst_len, src_ready, fifo_wr_en, fifo_wr_data, dbg_state
`ifdef FIFO_FILL_STAT_EN
    , burst_cnt, stall_cnt
`endif
  );

  modport slave (
    output start, data_len, abort, ack, src_valid, src_data, fifo_full, fifo_afull,
    input  busy, done, req, burst_len, src_ready, fifo_wr_en, fifo_wr_data, dbg_state
`ifdef FIFO_FILL_STAT_EN
    , burst_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/fifo_fill_ctrl.sv
// Write-side scheduler for the audio sample FIFO: requests bursts from the source,
// gates beats into the FIFO and counts against data_len. FIFO_FILL_STAT_EN adds stats.
module fifo_fill_ctrl
  import fifo_fill_pkg::*;
#(
  parameter int W     = 16,
  parameter int BURST = 32,
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  fifo_fill_ctrl_if.master bus
);

  fill_state_e      state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       burst_len_q, burst_len_d;
  logic             beat;
  logic [W-1:0]     wr_data;

  assign beat    = (state_q == XFER) && bus.src_valid && !bus.fifo_full;
  assign wr_data = bus.src_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = START;
          remaining_d = bus.data_len;
        end
      end
      START:      state_d = (remaining_q == '0) ? DONE : WAIT_SPACE;
      WAIT_SPACE: begin
        // Bursts are sized to fit whenever afull is low, so no finer check is needed.
        if (!bus.fifo_afull) begin
          state_d     = REQ;
          burst_len_d = clip_burst(64'(remaining_q), 8'(BURST));
          beat_cnt_d  = '0;
        end
      end
      REQ: begin
        if (bus.ack) state_d = XFER;
      end
      XFER: begin
        if (beat) begin
          beat_cnt_d  = beat_cnt_q + 8'd1;
          remaining_d = (remaining_q == '0) ? '0 : remaining_q - 1'b1;
          if (beat_cnt_q == burst_len_q - 8'd1)
            state_d = (remaining_d == '0) ? DONE : WAIT_SPACE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over start, ack and the final beat alike.
    if (bus.abort) begin
      state_d     = IDLE;
      remaining_d = '0;
      beat_cnt_d  = '0;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.req          = (state_q == REQ);
  assign bus.burst_len    = burst_len_q;
  assign bus.src_ready    = (state_q == XFER) && !bus.fifo_full;
  assign bus.fifo_wr_en   = beat;
  assign bus.fifo_wr_data = wr_data;
  assign bus.dbg_state    = state_q;

`ifdef FIFO_FILL_STAT_EN
  logic [STAT_W-1:0] burst_cnt_q, stall_cnt_q;
  logic              stat_clr;

  assign stat_clr = (state_q == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (stat_clr) begin
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((state_q == REQ) && bus.ack && (burst_cnt_q != '1))
        burst_cnt_q <= burst_cnt_q + 1'b1;
      if ((state_q == XFER) && bus.fifo_full && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.burst_cnt = burst_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl: vector table of transfers plus
// hand-written afull, abort, ack and reset sequences.
module tb_fifo_fill_ctrl;
  import fifo_fill_pkg::*;

  localparam int W     = 16;
  localparam int BURST = 32;
  localparam int LEN_W = 32;

  typedef struct {
    int len;
    int nb;
    int last;
    bit inj_full;
    bit rnd;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fifo_fill_ctrl_if #(.W(W), .LEN_W(LEN_W)) bus ();

  fifo_fill_ctrl #(.W(W), .BURST(BURST), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   burst_q[$];
  int           n_writes = 0;
  int           n_bursts = 0;
  int           n_done = 0;
  int           cyc = 0;
  int           done_cyc = 0;
  bit           fire_q = 0;
  bit           req_prev = 0;
  bit           done_prev = 0;
  bit           ack_pend = 0;
  bit           ack_en = 1;
  bit           ack_force = 0;
  bit           src_on = 1;
  bit           src_rand = 0;
  logic [W-1:0] word = 16'h1000;
  vec_t         vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops on every FIFO write, burst and done tracking.
  initial begin
    forever begin
      @(negedge clk);
      fire_q = bus.src_valid && bus.src_ready;
      if (bus.fifo_wr_en === 1'b1) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h expected=no write (t=%0t)",
                   bus.fifo_wr_data, $time);
        end else begin
          check("wr_data", bus.fifo_wr_data, exp_q.pop_front());
        end
      end
      if (bus.fifo_full) begin
        check("ready_when_full", bus.src_ready, 0);
        check("wr_when_full", bus.fifo_wr_en, 0);
      end
      if (bus.req && !req_prev) begin
        n_bursts++;
        burst_q.push_back(bus.burst_len);
      end
      req_prev = bus.req;
      if (done_prev) check("busy_after_done", bus.busy, 0);
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      done_prev = bus.done;
    end
  end

  // Source: presents an incrementing word, advancing only after an accepted beat.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fire_q) word = word + 16'd1;
      bus.src_data  = word;
      bus.src_valid = src_on && (src_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
  end

  // Ack responder: acks one cycle after it sees req.
  initial begin
    forever begin
      @(negedge clk);
      ack_pend = ack_en && bus.req && !bus.ack;
      @(posedge clk);
      #2;
      bus.ack = ack_pend || ack_force;
    end
  end

  task automatic push_words(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(word + W'(k));
  endtask

  task automatic wait_done(input int s_done, input int s_writes, input bit inj);
    int  full_left;
    bit  injected;
    full_left = 0;
    injected  = 0;
    for (int t = 0; t < 3000 && n_done == s_done; t++) begin
      tick();
      if (inj && !injected && (n_writes - s_writes) >= 10) begin
        bus.fifo_full = 1'b1;
        full_left     = 5;
        injected      = 1;
      end else if (full_left > 0) begin
        full_left--;
        if (full_left == 0) bus.fifo_full = 1'b0;
      end
    end
    bus.fifo_full = 1'b0;
    if (n_done == s_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done expected=done pulse (t=%0t)", $time);
    end
  endtask

  task automatic wait_req();
    for (int t = 0; t < 200 && !bus.req; t++) tick();
    check("req_seen", bus.req, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int s_writes, s_done, s_bursts, start_cyc;
    s_writes = n_writes;
    s_done   = n_done;
    s_bursts = n_bursts;
    burst_q.delete();
    src_rand = v.rnd;
    push_words(v.len);
    bus.start    = 1'b1;
    bus.data_len = LEN_W'(v.len);
    start_cyc    = cyc;
    tick();
    bus.start = 1'b0;
    wait_done(s_done, s_writes, v.inj_full);
    tick();
    tick();
    check("writes", n_writes - s_writes, v.len);
    check("done_count", n_done - s_done, 1);
    check("bursts", n_bursts - s_bursts, v.nb);
    for (int b = 0; b < burst_q.size(); b++)
      check("burst_len", burst_q[b], (b == burst_q.size() - 1) ? v.last : BURST);
    if (v.len == 0) check("zero_len_done_lat", done_cyc - start_cyc, 2);
`ifdef FIFO_FILL_STAT_EN
    if (v.inj_full) begin
      check("burst_cnt", bus.burst_cnt, v.nb);
      check("stall_cnt", bus.stall_cnt, 5);
    end
`endif
    check("idle_busy", bus.busy, 0);
    src_rand = 0;
  endtask

  initial begin
    int s_done, s_writes;
    bus.start      = 1'b0;
    bus.data_len   = '0;
    bus.abort      = 1'b0;
    bus.ack        = 1'b0;
    bus.src_valid  = 1'b0;
    bus.src_data   = '0;
    bus.fifo_full  = 1'b0;
    bus.fifo_afull = 1'b0;

    vecs[0] = '{len: 70, nb: 3, last: 6,  inj_full: 0, rnd: 0};
    vecs[1] = '{len: 0,  nb: 0, last: 0,  inj_full: 0, rnd: 0};
    vecs[2] = '{len: 32, nb: 1, last: 32, inj_full: 0, rnd: 0};
    vecs[3] = '{len: 33, nb: 2, last: 1,  inj_full: 0, rnd: 0};
    vecs[4] = '{len: 1,  nb: 1, last: 1,  inj_full: 0, rnd: 0};
    vecs[5] = '{len: 70, nb: 3, last: 6,  inj_full: 1, rnd: 0};
    vecs[6] = '{len: 45, nb: 2, last: 13, inj_full: 0, rnd: 1};
    vecs[7] = '{len: 64, nb: 2, last: 32, inj_full: 0, rnd: 1};

    // Reset values, with the source already offering beats.
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_req", bus.req, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_wr_en", bus.fifo_wr_en, 0);
    check("rst_burst_len", bus.burst_len, 0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Almost-full held for 20 cycles blocks the request.
    s_done   = n_done;
    s_writes = n_writes;
    push_words(8);
    bus.fifo_afull = 1'b1;
    bus.start      = 1'b1;
    bus.data_len   = 32'd8;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("req_while_afull", bus.req, 0);
      tick();
    end
    bus.fifo_afull = 1'b0;
    @(negedge clk);
    check("req_same_cycle_afull_low", bus.req, 0);
    tick();
    @(negedge clk);
    check("req_after_afull_low", bus.req, 1);
    wait_done(s_done, s_writes, 0);
    tick();
    check("afull_writes", n_writes - s_writes, 8);

    // Abort while waiting for ack.
    ack_en   = 0;
    s_done   = n_done;
    s_writes = n_writes;
    bus.start    = 1'b1;
    bus.data_len = 32'd40;
    tick();
    bus.start = 1'b0;
    wait_req();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_req_req", bus.req, 0);
    check("abort_req_busy", bus.busy, 0);
    check("abort_req_ready", bus.src_ready, 0);
    repeat (5) tick();
    check("abort_req_no_done", n_done - s_done, 0);
    check("abort_req_no_writes", n_writes - s_writes, 0);
    ack_en = 1;

    // Abort after 10 beats; the coincident 11th beat is still written.
    s_done   = n_done;
    s_writes = n_writes;
    push_words(11);
    bus.start    = 1'b1;
    bus.data_len = 32'd40;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < 300 && (n_writes - s_writes) < 10; t++) tick();
    check("abort_xfer_pre_beats", n_writes - s_writes, 10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_xfer_req", bus.req, 0);
    check("abort_xfer_ready", bus.src_ready, 0);
    check("abort_xfer_busy", bus.busy, 0);
    repeat (5) tick();
    check("abort_xfer_writes", n_writes - s_writes, 11);
    check("abort_xfer_no_done", n_done - s_done, 0);

    run_vec('{len: 20, nb: 1, last: 20, inj_full: 0, rnd: 0});

    // Start together with abort, and a stray ack, both leave the block idle.
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    bus.data_len = 32'd5;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", bus.busy, 0);
    ack_force = 1;
    tick();
    tick();
    ack_force = 0;
    @(negedge clk);
    check("stray_ack_busy", bus.busy, 0);
    check("stray_ack_req", bus.req, 0);
    tick();

    // Asynchronous reset mid-request drops req without a clock edge.
    ack_en = 0;
    bus.start    = 1'b1;
    bus.data_len = 32'd10;
    tick();
    bus.start = 1'b0;
    wait_req();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", bus.req, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_burst_len", bus.burst_len, 0);
`ifdef FIFO_FILL_STAT_EN
    check("async_rst_burst_cnt", bus.burst_cnt, 0);
`endif
    tick();
    reset_n = 1'b1;
    ack_en  = 1;
    tick();

    run_vec('{len: 3, nb: 1, last: 3, inj_full: 0, rnd: 0});

    repeat (5) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_fill_ctrl.md
Name: fifo_fill_ctrl

Overview:
- Write-side scheduler for the audio sample FIFO, running in the FIFO write clock domain.
- Watches the FIFO level flags and issues burst requests to the upstream sample source (SD/WAV reader).
- Gates the source's beats into the FIFO write port and counts words against a programmed WAV data length.
- Signals completion, and supports abort mid-stream.

Parameters:
- W, 16, sample/data width; must match the FIFO width.
- BURST, 32, maximum words per burst request; must be <= FIFO depth/2 + 1, so a burst started while afull is low always fits.
- LEN_W, 32, width of the word-length and remaining counters.

Ports:
- clk  input  1  clock; same clock as the FIFO wr_clk.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a transfer of data_len words.
- data_len  input  LEN_W  words to transfer; sampled on accepted start.
- abort  input  1  terminates the transfer; back to IDLE next cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is written.
- req  output  1  burst request; held high until ack.
- burst_len  output  8  words in the current burst; valid while req is high.
- ack  input  1  source accepts the request; sampled only while req is high.
- src_valid  input  1  source beat valid.
- src_data  input  W  source beat data.
- src_ready  output  1  controller accepts the beat.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  W  FIFO write data.
- fifo_full  input  1  FIFO full flag.
- fifo_afull  input  1  FIFO almost-full flag.

Behaviour:
- Reset: state=IDLE, remaining=0, beat_cnt=0. Outputs busy, done, req, src_ready and fifo_wr_en are 0; burst_len=0.
- States and transitions:
  - IDLE -> START: start=1 && abort=0 latches remaining=data_len.
  - START -> IDLE: if remaining==0, pulse done the next cycle and return to IDLE.
  - START -> WAIT_SPACE: otherwise.
  - WAIT_SPACE -> REQ: when fifo_afull==0. Register burst_len=min(BURST, remaining) and clear beat_cnt.
  - REQ: req=1. When ack=1, go to XFER next cycle.
  - XFER: src_ready = !fifo_full.
    - Beat = src_valid && src_ready.
    - fifo_wr_en = beat and fifo_wr_data = src_data, combinationally (zero latency).
    - Each beat increments beat_cnt and decrements remaining.
  - XFER exit: on the beat where beat_cnt reaches burst_len-1:
    - if remaining becomes 0, go to DONE;
    - otherwise go to WAIT_SPACE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Boundaries:
  - src_ready is 0 outside XFER. Source beats offered there are ignored and never written.
  - fifo_full high mid-burst stalls the burst: src_ready=0, counters hold. Resume when full clears.
  - Last burst is short when remaining < BURST; burst_len reflects it.
  - remaining decrement never wraps below 0.
  - start while busy is ignored.
  - abort has priority over every other event, including start in IDLE and the final beat.
    - Next state is IDLE; req and src_ready drop the next cycle; done is not pulsed.
    - A beat coincident with abort is still written (combinational path).
  - ack outside REQ is ignored.
  - Reset mid-operation returns to reset values immediately; req drops asynchronously.

Optional Feature:
- Macro: FIFO_FILL_STAT_EN.
- Defined: adds outputs burst_cnt[15:0] and stall_cnt[15:0].
  - burst_cnt counts accepted requests (req && ack).
  - stall_cnt counts XFER cycles with fifo_full=1.
  - Both saturate at 16'hFFFF, clear on reset and on accepted start.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_fill_pkg holds:
  - state encoding constants IDLE, START, WAIT_SPACE, REQ, XFER, DONE (3-bit);
  - stat counter width 16.
- No sub-module needed; the optional stats counters may be a small sub-module fifo_fill_stat.

Test Plan:
- start, data_len=70, BURST=32, fifo_afull=0, ack one cycle after req, src_valid always 1 -> bursts of 32, 32, 6; exactly 70 fifo_wr_en pulses; done pulses once; busy drops the cycle after done.
- start, data_len=0 -> no req; done pulses two cycles after start; no fifo writes.
- fifo_afull=1 held 20 cycles after start -> req stays 0 for all 20 cycles; req rises the cycle after afull falls.
- fifo_full=1 for 5 cycles mid-burst -> src_ready=0 and no writes for those 5 cycles; burst completes with the correct total count.
- abort asserted in REQ and, separately, in XFER after 10 beats -> IDLE next cycle, req/src_ready 0, no done; new start then completes normally.
- With FIFO_FILL_STAT_EN: the 70-word transfer with 5 full cycles -> burst_cnt=3, stall_cnt=5.
